// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue register with operand forwarding and ALU function decode.
// Define ALU_ISSUE_PERF_EN to add the perf_issued/perf_stall counters; otherwise both read 0.
module alu_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic          exm_wr,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          wb_wr,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [5:0]    alufn,
  output logic [RW-1:0] rd_out,
  output logic          reg_wr,
  output logic          illegal,
  output logic [31:0]   perf_issued,
  output logic [31:0]   perf_stall
);
  logic          out_valid_q, out_valid_d, reg_wr_q, reg_wr_d, illegal_q, illegal_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [5:0]    alufn_q, alufn_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [5:0]    op, fn, dec_fn;
  logic [RW-1:0] rs_idx, rt_idx, dec_rd;
  logic [DW-1:0] rs_v, rt_v, sext, zext, shamt, dec_a, dec_b;
  logic          legal, fire;

  assign in_ready = !out_valid_q || out_ready;
  assign fire     = in_valid && in_ready && !flush;

  always_comb begin
    op     = instr[31:26];
    fn     = instr[5:0];
    rs_idx = RW'(instr[25:21]);
    rt_idx = RW'(instr[20:16]);
    rs_v   = rs_idx == '0 ? '0 : (exm_wr && exm_rd == rs_idx) ? exm_data : (wb_wr && wb_rd == rs_idx) ? wb_data : rs_data;
    rt_v   = rt_idx == '0 ? '0 : (exm_wr && exm_rd == rt_idx) ? exm_data : (wb_wr && wb_rd == rt_idx) ? wb_data : rt_data;
    sext   = {{(DW-16){instr[15]}}, instr[15:0]};
    zext   = DW'(instr[15:0]);
    shamt  = DW'(instr[10:6]);
    legal  = 1'b1;
    dec_a  = rs_v;
    dec_b  = rt_v;
    dec_fn = 6'b111111;
    dec_rd = op == 6'h00 ? RW'(instr[15:11]) : rt_idx;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: dec_fn = 6'b000000;
        6'h22, 6'h23: dec_fn = 6'b000001;
        6'h18:        dec_fn = 6'b000010;
        6'h24:        dec_fn = 6'b000100;
        6'h25:        dec_fn = 6'b000101;
        6'h26:        dec_fn = 6'b000110;
        6'h2a:        dec_fn = 6'b001011;
        6'h00, 6'h02: begin
          dec_fn = fn == 6'h00 ? 6'b001000 : 6'b001001;
          dec_a  = rt_v;
          dec_b  = shamt;
        end
        default:      legal = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin dec_fn = 6'b000000; dec_b = sext; end
        6'h0a:        begin dec_fn = 6'b001011; dec_b = sext; end
        6'h0c:        begin dec_fn = 6'b000100; dec_b = zext; end
        6'h0d:        begin dec_fn = 6'b000101; dec_b = zext; end
        6'h0e:        begin dec_fn = 6'b000110; dec_b = zext; end
        6'h0f:        begin dec_fn = 6'b001000; dec_a = zext; dec_b = DW'(16); end
        default:      legal = 1'b0;
      endcase
    end
    if (!legal) begin
      dec_fn = 6'b111111;
      dec_a  = '0;
      dec_b  = '0;
    end
  end

  always_comb begin
    out_valid_d = flush ? 1'b0 : fire ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    reg_wr_d    = flush ? 1'b0 : fire ? (legal && dec_rd != '0) : reg_wr_q;
    illegal_d   = flush ? 1'b0 : fire ? !legal : illegal_q;
    a_d         = fire ? dec_a : a_q;
    b_d         = fire ? dec_b : b_q;
    alufn_d     = fire ? dec_fn : alufn_q;
    rd_d        = fire ? dec_rd : rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      reg_wr_q    <= 1'b0;
      illegal_q   <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      alufn_q     <= 6'b111111;
      rd_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      reg_wr_q    <= reg_wr_d;
      illegal_q   <= illegal_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alufn_q     <= alufn_d;
      rd_q        <= rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign reg_wr    = reg_wr_q;
  assign illegal   = illegal_q;
  assign a         = a_q;
  assign b         = b_q;
  assign alufn     = alufn_q;
  assign rd_out    = rd_q;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issued_q, issued_d, stall_q, stall_d;

  always_comb begin
    issued_d = issued_q + 32'(out_valid_q && out_ready);
    stall_d  = stall_q + 32'(out_valid_q && !out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`else
  assign perf_issued = '0;
  assign perf_stall  = '0;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed table, corner sequences and randomized traffic against a reference model.
module tb_alu_issue_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 0, rst = 0;
  logic          in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 1;
  logic [31:0]   instr = 0;
  logic [DW-1:0] rs_data = 0, rt_data = 0, exm_data = 0, wb_data = 0, a, b;
  logic          exm_wr = 0, wb_wr = 0, reg_wr, illegal;
  logic [RW-1:0] exm_rd = 0, wb_rd = 0, rd_out;
  logic [5:0]    alufn;
  logic [31:0]   perf_issued, perf_stall;

  always #5 clk = ~clk;

  alu_issue_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .a(a), .b(b), .alufn(alufn), .rd_out(rd_out), .reg_wr(reg_wr),
    .illegal(illegal), .perf_issued(perf_issued), .perf_stall(perf_stall)
  );

  typedef struct packed {
    logic [31:0] a, b;
    logic [5:0]  fn;
    logic [4:0]  rd;
    logic        wr, ill;
  } res_t;

  typedef struct packed {
    logic [31:0] instr, rs, rt;
    logic        ew;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wd, ea, eb;
    logic [5:0]  efn;
    logic [4:0]  erdo;
    logic        ewr, eill;
  } vec_t;

  int   vecs = 0, errs = 0;
  logic mv = 0, clean = 1;
  res_t m = '0;
  int   m_iss = 0, m_stl = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] src, input logic [31:0] rf);
    if (src == 0) return 0;
    if (exm_wr && exm_rd == src) return exm_data;
    if (wb_wr && wb_rd == src) return wb_data;
    return rf;
  endfunction

  function automatic res_t model(input logic [31:0] ins);
    res_t        r;
    int          op, fn;
    logic [31:0] s, t;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    s = opnd(ins[25:21], rs_data);
    t = opnd(ins[20:16], rt_data);
    r = '0;
    r.ill = 1;
    r.fn = 6'h3f;
    if (op == 0) begin
      r.rd = ins[15:11];
      if (fn inside {'h20, 'h21, 'h22, 'h23, 'h18, 'h24, 'h25, 'h26, 'h2a}) begin
        r.a = s;
        r.b = t;
        r.ill = 0;
        r.fn = fn inside {'h20, 'h21} ? 6'd0 : fn inside {'h22, 'h23} ? 6'd1 :
               fn == 'h18 ? 6'd2 : fn == 'h2a ? 6'd11 : 6'(fn - 'h20);
      end else if (fn == 0 || fn == 2) begin
        r.a = t;
        r.b = 32'(ins[10:6]);
        r.fn = fn == 0 ? 6'd8 : 6'd9;
        r.ill = 0;
      end
    end else if (op inside {8, 9, 'h0a, 'h0c, 'h0d, 'h0e, 'h0f}) begin
      r.rd = ins[20:16];
      r.ill = 0;
      r.a = op == 'h0f ? 32'(ins[15:0]) : s;
      r.b = op == 'h0f ? 32'd16 : op < 'h0c ? 32'(int'($signed(ins[15:0]))) : 32'(ins[15:0]);
      r.fn = op < 'h0a ? 6'd0 : op == 'h0a ? 6'd11 : op == 'h0f ? 6'd8 : 6'(op - 8);
    end
    r.wr = !r.ill && r.rd != 0;
    return r;
  endfunction

  task automatic check_perf();
`ifdef ALU_ISSUE_PERF_EN
    chk("perf_issued", perf_issued, m_iss);
    chk("perf_stall", perf_stall, m_stl);
`else
    chk("perf_issued", perf_issued, 0);
    chk("perf_stall", perf_stall, 0);
`endif
  endtask

  task automatic cycle();
    #1;
    chk("in_ready", in_ready, !mv || out_ready);
    @(posedge clk);
    if (mv && out_ready) m_iss++;
    if (mv && !out_ready) m_stl++;
    if (flush) begin
      mv = 0;
      clean = 1;
    end else if (in_valid && (!mv || out_ready)) begin
      mv = 1;
      clean = 0;
      m = model(instr);
    end else if (out_ready) mv = 0;
    #1;
    chk("out_valid", out_valid, mv);
    if (mv) begin
      chk("a", a, m.a);
      chk("b", b, m.b);
      chk("alufn", alufn, m.fn);
      if (!m.ill) chk("rd_out", rd_out, m.rd);
      chk("reg_wr", reg_wr, m.wr);
      chk("illegal", illegal, m.ill);
    end else if (clean) begin
      chk("reg_wr_idle", reg_wr, 0);
      chk("illegal_idle", illegal, 0);
    end
    check_perf();
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    mv = 0;
    clean = 1;
    m_iss = 0;
    m_stl = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_alufn", alufn, 6'h3f);
    chk("rst_rd_out", rd_out, 0);
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_perf_issued", perf_issued, 0);
    chk("rst_perf_stall", perf_stall, 0);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic set_ops(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    instr = ins;
    rs_data = rs;
    rt_data = rt;
    exm_wr = 0;
    wb_wr = 0;
  endtask

  initial begin
    vec_t tbl[$];
    logic [5:0] ops[12] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h00};
    logic [5:0] fns[12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h18, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h2a, 6'h00};
    tbl.push_back('{32'h00221820, 5, 7, 0, 0, 0, 0, 0, 0, 5, 7, 6'h00, 3, 1, 0});
    tbl.push_back('{32'h00221820, 5, 7, 1, 1, 32'h10, 1, 1, 32'h20, 32'h10, 7, 6'h00, 3, 1, 0});
    tbl.push_back('{32'h00221820, 5, 7, 0, 1, 32'h10, 1, 1, 32'h20, 32'h20, 7, 6'h00, 3, 1, 0});
    tbl.push_back('{32'h00021820, 5, 7, 1, 0, 32'h10, 1, 0, 32'h20, 0, 7, 6'h00, 3, 1, 0});
    tbl.push_back('{32'h2024FFFF, 0, 7, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 6'h00, 4, 1, 0});
    tbl.push_back('{32'h3C051234, 9, 9, 0, 0, 0, 0, 0, 0, 32'h1234, 16, 6'h08, 5, 1, 0});
    tbl.push_back('{32'h8C220004, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 6'h3f, 0, 0, 1});
    tbl.push_back('{32'h00031100, 1, 32'hABCD, 0, 0, 0, 0, 0, 0, 32'hABCD, 4, 6'h08, 2, 1, 0});
    tbl.push_back('{32'h00043FC2, 1, 32'h80000000, 0, 0, 0, 0, 0, 0, 32'h80000000, 31, 6'h09, 7, 1, 0});
    tbl.push_back('{32'h00220020, 5, 7, 0, 0, 0, 0, 0, 0, 5, 7, 6'h00, 0, 0, 0});
    tbl.push_back('{32'h2826FFFE, 9, 0, 0, 0, 0, 0, 0, 0, 9, 32'hFFFFFFFE, 6'h0B, 6, 1, 0});
    tbl.push_back('{32'h30288000, 9, 0, 0, 0, 0, 0, 0, 0, 9, 32'h8000, 6'h04, 8, 1, 0});
    tbl.push_back('{32'h34290F0F, 9, 0, 0, 0, 0, 0, 0, 0, 9, 32'h0F0F, 6'h05, 9, 1, 0});
    tbl.push_back('{32'h382AFFFF, 9, 0, 0, 0, 0, 0, 0, 0, 9, 32'hFFFF, 6'h06, 10, 1, 0});
    tbl.push_back('{32'h0022183F, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 6'h3f, 0, 0, 1});
    tbl.push_back('{32'h00221820, 5, 7, 1, 1, 32'h66, 1, 2, 32'h55, 32'h66, 32'h55, 6'h00, 3, 1, 0});
    tbl.push_back('{32'h00221818, 5, 7, 0, 0, 0, 0, 0, 0, 5, 7, 6'h02, 3, 1, 0});
    tbl.push_back('{32'h00221823, 5, 7, 0, 0, 0, 0, 0, 0, 5, 7, 6'h01, 3, 1, 0});
    #1;
    do_reset();
    foreach (tbl[i]) begin
      instr = tbl[i].instr;
      rs_data = tbl[i].rs;
      rt_data = tbl[i].rt;
      exm_wr = tbl[i].ew;
      exm_rd = tbl[i].erd;
      exm_data = tbl[i].ed;
      wb_wr = tbl[i].ww;
      wb_rd = tbl[i].wrd;
      wb_data = tbl[i].wd;
      in_valid = 1;
      out_ready = 1;
      flush = 0;
      cycle();
      chk("tbl_valid", out_valid, 1);
      chk("tbl_a", a, tbl[i].ea);
      chk("tbl_b", b, tbl[i].eb);
      chk("tbl_alufn", alufn, tbl[i].efn);
      if (!tbl[i].eill) chk("tbl_rd_out", rd_out, tbl[i].erdo);
      chk("tbl_reg_wr", reg_wr, tbl[i].ewr);
      chk("tbl_illegal", illegal, tbl[i].eill);
    end
    do_reset();
    set_ops(32'h00221820, 5, 7);
    in_valid = 1;
    out_ready = 1;
    cycle();
    set_ops(32'h3C051234, 0, 0);
    out_ready = 0;
    repeat (3) begin
      cycle();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_a", a, 5);
      chk("stall_alufn", alufn, 6'h00);
    end
`ifdef ALU_ISSUE_PERF_EN
    chk("stall_count", perf_stall, 3);
`endif
    out_ready = 1;
    cycle();
    chk("release_a", a, 32'h1234);
    chk("release_alufn", alufn, 6'h08);
    set_ops(32'h00221820, 5, 7);
    flush = 1;
    cycle();
    chk("flush_valid", out_valid, 0);
    chk("flush_reg_wr", reg_wr, 0);
    flush = 0;
    in_valid = 0;
    cycle();
    chk("flush_lost", out_valid, 0);
    in_valid = 1;
    cycle();
    out_ready = 0;
    cycle();
    #2;
    do_reset();
    out_ready = 1;
    in_valid = 0;
    cycle();
    repeat (800) begin
      int k = $urandom_range(0, 11);
      logic [5:0] op = k == 11 ? 6'($urandom) : ops[k];
      int j = $urandom_range(0, 11);
      instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      if (op == 0) instr[5:0] = j == 11 ? 6'($urandom) : fns[j];
      rs_data = $urandom;
      rt_data = $urandom;
      exm_wr = 1'($urandom);
      exm_rd = 5'($urandom_range(0, 7));
      exm_data = $urandom;
      wb_wr = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 19) == 0;
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
